// File: rtl/result_drain.sv
// rtl/result_drain.sv - PE result cache drain: frame readout, length/error checks, FWFT output buffer
// Define RESULT_DRAIN_TIMEOUT_EN to build the RECV stall watchdog (err_code 3).

module result_drain_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   can_push,
  output logic [$clog2(DEPTH):0] count,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, do_push, do_pop;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_valid = (wr_ptr_q != rd_ptr_q);
    rd_data  = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    do_pop   = rd_valid && rd_ready;
    // a full buffer still takes a word when the head leaves in the same cycle
    can_push = !full || do_pop;
    do_push  = push && can_push;
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

module result_drain #(
  parameter int WORDS_PER_FRAME = 32,
  parameter int FIFO_DEPTH      = 64,
  parameter int TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        top_rd_sop,
  input  logic        top_rd_vld,
  input  logic [31:0] top_rd_data,
  input  logic        top_rd_eop,
  input  logic        top_rd_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [CW-1:0] WPF      = CW'(WORDS_PER_FRAME);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_FRAME - 1);
  localparam logic [AW:0]   MAX_OCC  = (AW+1)'(FIFO_DEPTH - WORDS_PER_FRAME);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, RECV, DONE} state_t;

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          top_rd_sop_q, top_rd_sop_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          push, push_last, can_push, len_err, tmo;
  logic [AW:0]   occ;
  logic [32:0]   head;

`ifdef RESULT_DRAIN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;

  assign tmo = (state_q == RECV) && !top_rd_vld && ((wd_q + WW'(1)) == WW'(TIMEOUT));
`else
  // no watchdog in this build: tmo can never fire
  assign tmo = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    top_rd_sop_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    err_code_d   = err_code_q;
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q + CW'(1);
    push         = 1'b0;
    push_last    = 1'b0;
    len_err      = 1'b0;
`ifdef RESULT_DRAIN_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    if (start && (state_q != IDLE) && (state_q != DONE)) begin
      pending_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_SPACE;
          busy_d  = 1'b1;
        end
      end
      WAIT_SPACE: begin
        // the cache cannot be stalled, so a whole frame of room is reserved up front
        if (occ <= MAX_OCC) begin
          state_d      = REQ;
          top_rd_sop_d = 1'b1;
          cnt_d        = '0;
          frame_err_d  = 1'b0;
          err_code_d   = 2'd0;
`ifdef RESULT_DRAIN_TIMEOUT_EN
          wd_d         = '0;
`endif
        end
      end
      REQ: begin
        state_d = RECV;
      end
      RECV: begin
        if (top_rd_vld) begin
          if (cnt_q < WPF) begin
            if (can_push) begin
              push      = 1'b1;
              push_last = top_rd_eop || (cnt_q == LAST_IDX);
            end else begin
              len_err = 1'b1;
            end
            cnt_d = cnt_inc;
          end else begin
            len_err = 1'b1;
          end
          if (top_rd_eop) begin
            if (cnt_inc != WPF) begin
              len_err = 1'b1;
            end
            state_d = DONE;
          end
        end
`ifdef RESULT_DRAIN_TIMEOUT_EN
        wd_d = top_rd_vld ? '0 : wd_q + WW'(1);
        if (tmo) begin
          state_d = DONE;
        end
`endif
        if (err_code_q == 2'd0) begin
          if (top_rd_err) begin
            err_code_d = 2'd1;
          end else if (len_err) begin
            err_code_d = 2'd2;
          end else if (tmo) begin
            err_code_d = 2'd3;
          end
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        frame_err_d  = (err_code_q != 2'd0);
        if (pending_q || start) begin
          state_d   = WAIT_SPACE;
          busy_d    = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      top_rd_sop_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 2'd0;
      cnt_q        <= '0;
`ifdef RESULT_DRAIN_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      top_rd_sop_q <= top_rd_sop_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      cnt_q        <= cnt_d;
`ifdef RESULT_DRAIN_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  result_drain_fifo #(
    .WIDTH(33),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({push_last, top_rd_data}),
    .can_push (can_push),
    .count    (occ),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head)
  );

  assign out_data   = head[31:0];
  assign out_last   = head[32];
  assign busy       = busy_q;
  assign top_rd_sop = top_rd_sop_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
endmodule
